cmos_rgb565_capture: RTL and testbench
======================================

// Module: cmos_rgb565_capture
// PURPOSE
//  Capture stage directly downstream of the OV7670 SCCB configuration block. Stays idle until the
//  sensor reports configuration complete, then discards FRAME_SKIP frames while the sensor settles.
//  After that it packs the 8-bit DVP byte stream into 16-bit RGB565 pixels for the SDRAM write FIFO.
//  Runs entirely in the sensor pixel-clock domain.
// PARAMETERS
//  FRAME_SKIP   10    frames discarded after iConfig_Done rises (0 = none); counter width 8 bits
//  H_PIXELS     640   expected pixels per line (used only with CAPTURE_STATS_EN)
//  V_LINES      480   expected lines per frame (used only with CAPTURE_STATS_EN)
// PORTS
//  iCLK          in   1   sensor PCLK; all logic on rising edge
//  iRST          in   1   synchronous reset, active-high
//  iConfig_Done  in   1   level from the SCCB config block; high = sensor configured
//  iCMOS_VSYNC   in   1   sensor VSYNC; a rising edge marks a frame boundary
//  iCMOS_HREF    in   1   sensor HREF; high = valid bytes on iCMOS_DATA
//  iCMOS_DATA    in   8   sensor data byte
//  oFrame_Valid  out  1   high while in CAPTURE
//  oFrame_Start  out  1   one-cycle pulse on entry to CAPTURE (each captured frame)
//  oData         out  16  RGB565 pixel {first byte, second byte}
//  oData_Valid   out  1   one-cycle strobe; oData is valid while high
//  oLine_Cnt     out  10  (CAPTURE_STATS_EN) lines in current/last frame
//  oPix_Cnt      out  10  (CAPTURE_STATS_EN) pixels in current/last line
//  oSize_Err     out  1   (CAPTURE_STATS_EN) sticky: a line or frame size mismatch occurred
// BEHAVIOUR
//  - Reset: all outputs 0; state WAIT_CFG; skip counter 0; byte toggle 0; input regs 0.
//  - VSYNC, HREF and DATA are registered once (stage r1). VSYNC has a second register (r2).
//    vs_rise = r1 & ~r2. All decisions use r1 values.
//  - FSM:
//      WAIT_CFG: go to SKIP when iConfig_Done=1 and FRAME_SKIP>0; go to WAIT_VS when FRAME_SKIP=0.
//      SKIP:     count vs_rise; when the count reaches FRAME_SKIP, clear the count and go to WAIT_VS.
//      WAIT_VS:  on vs_rise, go to CAPTURE and pulse oFrame_Start in the same edge.
//      CAPTURE:  pack pixels. On vs_rise, stay in CAPTURE, pulse oFrame_Start again, clear the toggle.
//  - iConfig_Done=0 in any state: go to WAIT_CFG next edge. oFrame_Valid drops and the toggle clears.
//    An in-flight half pixel is discarded.
//  - Packing, CAPTURE state with HREF_r1=1:
//      toggle=0: latch DATA_r1 into hi byte, toggle<=1.
//      toggle=1: oData<={hi, DATA_r1}, oData_Valid<=1, toggle<=0.
//  - Latency: the second byte appears at the pins at edge n; oData_Valid is high after edge n+2.
//  - HREF_r1=0: toggle<=0. An odd trailing byte is dropped silently; no partial pixel is emitted.
//  - vs_rise while HREF_r1=1 (malformed): vs_rise wins; toggle is cleared and no pixel is emitted
//    on that edge.
//  - oData holds its last value when oData_Valid=0. There is no backpressure; the downstream FIFO
//    must accept one pixel every 2 clocks.
// CONFIGURATION
//  CAPTURE_STATS_EN defined:
//    - oPix_Cnt increments per emitted pixel and clears on HREF_r1 falling edge (after compare).
//    - oLine_Cnt increments on each HREF_r1 falling edge and clears on vs_rise (after compare).
//    - Both saturate at 1023.
//    - oSize_Err is set when a line ends with oPix_Cnt!=H_PIXELS, or on vs_rise in CAPTURE with a
//      nonzero oLine_Cnt!=V_LINES. It is cleared only by iRST or by leaving WAIT_CFG.
//  CAPTURE_STATS_EN undefined:
//    - Counters and compare logic are absent.
//    - oLine_Cnt, oPix_Cnt and oSize_Err are tied to 0.
// TESTING
//  1 Reset mid-CAPTURE: assert iRST during a line -> next edge all outputs 0, FSM in WAIT_CFG.
//  2 FRAME_SKIP=2, iConfig_Done=1, 4 VSYNC pulses -> no oFrame_Start for pulses 1-2.
//    Pulse 3 gives WAIT_VS->CAPTURE with oFrame_Start. Pulse 4 pulses oFrame_Start again.
//  3 CAPTURE, HREF high with bytes 0xF8,0x1F,0x07,0xE0 -> oData_Valid twice, oData=0xF81F then 0x07E0.
//    First strobe is 2 clocks after byte 0x1F.
//  4 HREF high for 3 bytes then low -> exactly 1 pixel. The next line's first byte lands in the hi byte.
//  5 iConfig_Done falls mid-line -> oFrame_Valid 0 next edge, no further oData_Valid.
//    Restore: re-skips FRAME_SKIP frames.
//  6 STATS_EN, H_PIXELS=4, V_LINES=2: lines of 4,3 pixels -> oSize_Err=1 after second HREF fall.
//    Two lines of 4 pixels plus vs_rise -> oSize_Err stays 0.

Source files
------------

// File: rtl/cmos_rgb565_capture.sv
// OV7670 DVP capture: waits for sensor config, skips FRAME_SKIP frames, packs byte pairs into RGB565.
// Latency: a pixel strobes two clocks after its second byte is presented at the pins (one input stage + pack stage).
// Backpressure: none; the consumer must take one pixel every two clocks. Optional line/frame statistics under `CAPTURE_STATS_EN.
module cmos_rgb565_capture #(
    parameter int FRAME_SKIP = 10,
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iConfig_Done,
    input  logic        iCMOS_VSYNC,
    input  logic        iCMOS_HREF,
    input  logic [7:0]  iCMOS_DATA,
    output logic        oFrame_Valid,
    output logic        oFrame_Start,
    output logic [15:0] oData,
    output logic        oData_Valid,
    output logic [9:0]  oLine_Cnt,
    output logic [9:0]  oPix_Cnt,
    output logic        oSize_Err
);

    typedef enum logic [1:0] {
        S_WAIT_CFG = 2'd0,
        S_SKIP     = 2'd1,
        S_WAIT_VS  = 2'd2,
        S_CAPTURE  = 2'd3
    } state_t;

    localparam logic [7:0] LP_SKIP = FRAME_SKIP[7:0];

    state_t      r_state;
    logic        r_vs1;
    logic        r_vs2;
    logic        r_href1;
    logic [7:0]  r_data1;
    logic [7:0]  r_skip_cnt;
    logic        r_toggle;
    logic [7:0]  r_hi;
    logic [15:0] r_data;
    logic        r_data_vld;
    logic        r_frame_vld;
    logic        r_frame_start;
    logic        w_vs_rise;

    // Single input stage for all sensor pins; VSYNC gets a second stage for edge detection.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_vs1   <= 1'b0;
            r_vs2   <= 1'b0;
            r_href1 <= 1'b0;
            r_data1 <= 8'd0;
        end else begin
            r_vs1   <= iCMOS_VSYNC;
            r_vs2   <= r_vs1;
            r_href1 <= iCMOS_HREF;
            r_data1 <= iCMOS_DATA;
        end
    end

    assign w_vs_rise = r_vs1 & ~r_vs2;

    // Capture FSM with registered outputs; losing config always returns to WAIT_CFG and drops any half pixel.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state       <= S_WAIT_CFG;
            r_skip_cnt    <= 8'd0;
            r_toggle      <= 1'b0;
            r_hi          <= 8'd0;
            r_data        <= 16'd0;
            r_data_vld    <= 1'b0;
            r_frame_vld   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_data_vld    <= 1'b0;
            r_frame_start <= 1'b0;
            if (!iConfig_Done) begin
                r_state     <= S_WAIT_CFG;
                r_frame_vld <= 1'b0;
                r_toggle    <= 1'b0;
                r_skip_cnt  <= 8'd0;
            end else begin
                case (r_state)
                    S_WAIT_CFG: begin
                        r_skip_cnt <= 8'd0;
                        r_toggle   <= 1'b0;
                        if (LP_SKIP != 8'd0) begin
                            r_state <= S_SKIP;
                        end else begin
                            r_state <= S_WAIT_VS;
                        end
                    end
                    S_SKIP: begin
                        if (w_vs_rise) begin
                            if (r_skip_cnt + 8'd1 == LP_SKIP) begin
                                r_skip_cnt <= 8'd0;
                                r_state    <= S_WAIT_VS;
                            end else begin
                                r_skip_cnt <= r_skip_cnt + 8'd1;
                            end
                        end
                    end
                    S_WAIT_VS: begin
                        if (w_vs_rise) begin
                            r_state       <= S_CAPTURE;
                            r_frame_vld   <= 1'b1;
                            r_frame_start <= 1'b1;
                            r_toggle      <= 1'b0;
                        end
                    end
                    S_CAPTURE: begin
                        r_frame_vld <= 1'b1;
                        if (w_vs_rise) begin
                            // A new frame boundary wins over any byte on the same edge.
                            r_frame_start <= 1'b1;
                            r_toggle      <= 1'b0;
                        end else if (r_href1) begin
                            if (!r_toggle) begin
                                r_hi     <= r_data1;
                                r_toggle <= 1'b1;
                            end else begin
                                r_data     <= {r_hi, r_data1};
                                r_data_vld <= 1'b1;
                                r_toggle   <= 1'b0;
                            end
                        end else begin
                            // Odd trailing byte of a line is dropped here.
                            r_toggle <= 1'b0;
                        end
                    end
                    default: r_state <= S_WAIT_CFG;
                endcase
            end
        end
    end

    assign oFrame_Valid = r_frame_vld;
    assign oFrame_Start = r_frame_start;
    assign oData        = r_data;
    assign oData_Valid  = r_data_vld;

`ifdef CAPTURE_STATS_EN
    localparam logic [9:0] LP_H = H_PIXELS[9:0];
    localparam logic [9:0] LP_V = V_LINES[9:0];

    logic       r_href_d;
    logic [9:0] r_pix_cnt;
    logic [9:0] r_line_cnt;
    logic       r_size_err;
    logic       w_in_cap;
    logic       w_href_fall;
    logic       w_pix_emit;
    logic       w_cfg_leave;

    assign w_in_cap    = (r_state == S_CAPTURE) && iConfig_Done;
    assign w_href_fall = r_href_d & ~r_href1;
    assign w_pix_emit  = w_in_cap && !w_vs_rise && r_href1 && r_toggle;
    assign w_cfg_leave = (r_state == S_WAIT_CFG) && iConfig_Done;

    // Per-line pixel and per-frame line counters with size checking; error is sticky until a fresh start.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_href_d   <= 1'b0;
            r_pix_cnt  <= 10'd0;
            r_line_cnt <= 10'd0;
            r_size_err <= 1'b0;
        end else begin
            r_href_d <= r_href1;
            if (w_cfg_leave) begin
                r_pix_cnt  <= 10'd0;
                r_line_cnt <= 10'd0;
                r_size_err <= 1'b0;
            end else begin
                if (w_in_cap && w_href_fall) begin
                    if (r_pix_cnt != LP_H) begin
                        r_size_err <= 1'b1;
                    end
                    r_pix_cnt  <= 10'd0;
                    r_line_cnt <= (r_line_cnt == 10'd1023) ? r_line_cnt : r_line_cnt + 10'd1;
                end else if (w_pix_emit) begin
                    r_pix_cnt <= (r_pix_cnt == 10'd1023) ? r_pix_cnt : r_pix_cnt + 10'd1;
                end
                if (w_in_cap && w_vs_rise) begin
                    if ((r_line_cnt != 10'd0) && (r_line_cnt != LP_V)) begin
                        r_size_err <= 1'b1;
                    end
                    r_line_cnt <= 10'd0;
                end
            end
        end
    end

    assign oLine_Cnt = r_line_cnt;
    assign oPix_Cnt  = r_pix_cnt;
    assign oSize_Err = r_size_err;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{H_PIXELS, V_LINES};
    assign oLine_Cnt = 10'd0;
    assign oPix_Cnt  = 10'd0;
    assign oSize_Err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Directed bench for cmos_rgb565_capture with FRAME_SKIP=2, H_PIXELS=4, V_LINES=2.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at that same point.
// Statistics scenarios compile in only when CAPTURE_STATS_EN is defined.
module tb_cmos_rgb565_capture;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iConfig_Done;
    logic        iCMOS_VSYNC;
    logic        iCMOS_HREF;
    logic [7:0]  iCMOS_DATA;
    logic        oFrame_Valid;
    logic        oFrame_Start;
    logic [15:0] oData;
    logic        oData_Valid;
    logic [9:0]  oLine_Cnt;
    logic [9:0]  oPix_Cnt;
    logic        oSize_Err;

    int checks = 0;
    int errors = 0;

    always #5 iCLK = ~iCLK;

    cmos_rgb565_capture #(
        .FRAME_SKIP(2),
        .H_PIXELS  (4),
        .V_LINES   (2)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iConfig_Done(iConfig_Done),
        .iCMOS_VSYNC (iCMOS_VSYNC),
        .iCMOS_HREF  (iCMOS_HREF),
        .iCMOS_DATA  (iCMOS_DATA),
        .oFrame_Valid(oFrame_Valid),
        .oFrame_Start(oFrame_Start),
        .oData       (oData),
        .oData_Valid (oData_Valid),
        .oLine_Cnt   (oLine_Cnt),
        .oPix_Cnt    (oPix_Cnt),
        .oSize_Err   (oSize_Err)
    );

    task automatic cyc(input logic vs_i, input logic href_i, input logic [7:0] d_i);
        iCMOS_VSYNC = vs_i;
        iCMOS_HREF  = href_i;
        iCMOS_DATA  = d_i;
        @(posedge iCLK);
        #1;
    endtask

    // Two-cycle VSYNC pulse plus two idle cycles; reports whether oFrame_Start fired.
    task automatic vsync_pulse(output logic saw);
        saw = 1'b0;
        repeat (2) begin
            cyc(1'b1, 1'b0, 8'h00);
            saw = saw | oFrame_Start;
        end
        repeat (2) begin
            cyc(1'b0, 1'b0, 8'h00);
            saw = saw | oFrame_Start;
        end
    endtask

    // HREF high for nbytes incrementing bytes from base, then three idle cycles.
    task automatic send_line(input int nbytes, input logic [7:0] base,
                             output int npix, output logic [15:0] last);
        npix = 0;
        last = 16'h0000;
        for (int i = 0; i < nbytes; i++) begin
            cyc(1'b0, 1'b1, base + 8'(i));
            if (oData_Valid) begin npix++; last = oData; end
        end
        repeat (3) begin
            cyc(1'b0, 1'b0, 8'h00);
            if (oData_Valid) begin npix++; last = oData; end
        end
    endtask

    task automatic test_reset;
        iRST = 1'b1; iConfig_Done = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        checks++; if (oFrame_Valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", oFrame_Valid); end
        checks++; if (oFrame_Start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", oFrame_Start); end
        checks++; if (oData !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", oData); end
        checks++; if (oData_Valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", oData_Valid); end
        iRST = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_skip;
        logic saw;
        iConfig_Done = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        vsync_pulse(saw);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL skip_p1: start got %b want 0", saw); end
        vsync_pulse(saw);
        checks++; if (saw !== 1'b0 || oFrame_Valid !== 1'b0) begin errors++; $display("FAIL skip_p2: start %b fv %b want 0 0", saw, oFrame_Valid); end
        vsync_pulse(saw);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL skip_p3: start got %b want 1", saw); end
        checks++; if (oFrame_Valid !== 1'b1) begin errors++; $display("FAIL skip_p3_fv: got %b want 1", oFrame_Valid); end
        vsync_pulse(saw);
        checks++; if (saw !== 1'b1 || oFrame_Valid !== 1'b1) begin errors++; $display("FAIL skip_p4: start %b fv %b want 1 1", saw, oFrame_Valid); end
    endtask

    task automatic test_pack;
        cyc(1'b0, 1'b1, 8'hF8);
        checks++; if (oData_Valid !== 1'b0) begin errors++; $display("FAIL pack_b0: dv got %b want 0", oData_Valid); end
        cyc(1'b0, 1'b1, 8'h1F);
        checks++; if (oData_Valid !== 1'b0) begin errors++; $display("FAIL pack_b1: dv got %b want 0", oData_Valid); end
        cyc(1'b0, 1'b1, 8'h07);
        checks++; if (oData_Valid !== 1'b1 || oData !== 16'hF81F) begin errors++; $display("FAIL pack_px0: dv %b data %h want 1 f81f", oData_Valid, oData); end
        cyc(1'b0, 1'b1, 8'hE0);
        checks++; if (oData_Valid !== 1'b0 || oData !== 16'hF81F) begin errors++; $display("FAIL pack_hold: dv %b data %h want 0 f81f", oData_Valid, oData); end
        cyc(1'b0, 1'b0, 8'h00);
        checks++; if (oData_Valid !== 1'b1 || oData !== 16'h07E0) begin errors++; $display("FAIL pack_px1: dv %b data %h want 1 07e0", oData_Valid, oData); end
        cyc(1'b0, 1'b0, 8'h00);
        checks++; if (oData_Valid !== 1'b0 || oData !== 16'h07E0) begin errors++; $display("FAIL pack_idle: dv %b data %h want 0 07e0", oData_Valid, oData); end
    endtask

    task automatic test_odd_line;
        int n; logic [15:0] last;
        send_line(3, 8'hA1, n, last);
        checks++; if (n !== 1 || last !== 16'hA1A2) begin errors++; $display("FAIL odd_line: pix %0d data %h want 1 a1a2", n, last); end
        send_line(2, 8'h12, n, last);
        checks++; if (n !== 1 || last !== 16'h1213) begin errors++; $display("FAIL next_line: pix %0d data %h want 1 1213", n, last); end
    endtask

    task automatic test_reset_mid;
        logic saw;
        cyc(1'b0, 1'b1, 8'hAA);
        cyc(1'b0, 1'b1, 8'hBB);
        iRST = 1'b1;
        cyc(1'b0, 1'b1, 8'hCC);
        checks++; if (oData_Valid !== 1'b0 || oData !== 16'h0000) begin errors++; $display("FAIL rstmid_data: dv %b data %h want 0 0000", oData_Valid, oData); end
        checks++; if (oFrame_Valid !== 1'b0 || oFrame_Start !== 1'b0) begin errors++; $display("FAIL rstmid_frame: fv %b fs %b want 0 0", oFrame_Valid, oFrame_Start); end
        checks++; if (oLine_Cnt !== 10'd0 || oPix_Cnt !== 10'd0 || oSize_Err !== 1'b0) begin errors++; $display("FAIL rstmid_stats: line %0d pix %0d err %b want 0 0 0", oLine_Cnt, oPix_Cnt, oSize_Err); end
        iRST = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        vsync_pulse(saw);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_skip1: start got %b want 0", saw); end
        vsync_pulse(saw);
        vsync_pulse(saw);
        checks++; if (saw !== 1'b1 || oFrame_Valid !== 1'b1) begin errors++; $display("FAIL rstmid_recap: start %b fv %b want 1 1", saw, oFrame_Valid); end
    endtask

    task automatic test_cfg_drop;
        logic saw; int n; logic [15:0] last;
        cyc(1'b0, 1'b1, 8'h55);
        cyc(1'b0, 1'b1, 8'h66);
        iConfig_Done = 1'b0;
        cyc(1'b0, 1'b1, 8'h77);
        checks++; if (oFrame_Valid !== 1'b0 || oData_Valid !== 1'b0) begin errors++; $display("FAIL cfgdrop_now: fv %b dv %b want 0 0", oFrame_Valid, oData_Valid); end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 8'(8'h80 + i));
            if (oData_Valid) n++;
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++; if (n !== 0) begin errors++; $display("FAIL cfgdrop_quiet: pixels %0d want 0", n); end
        iConfig_Done = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        vsync_pulse(saw);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL cfgdrop_skip1: start got %b want 0", saw); end
        vsync_pulse(saw);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL cfgdrop_skip2: start got %b want 0", saw); end
        vsync_pulse(saw);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL cfgdrop_recap: start got %b want 1", saw); end
        send_line(4, 8'h40, n, last);
        checks++; if (n !== 2 || last !== 16'h4243) begin errors++; $display("FAIL cfgdrop_line: pix %0d data %h want 2 4243", n, last); end
    endtask

    task automatic restart_capture;
        logic saw;
        iConfig_Done = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        iConfig_Done = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        repeat (3) vsync_pulse(saw);
    endtask

    task automatic test_stats;
        int n; logic [15:0] last; logic saw;
`ifdef CAPTURE_STATS_EN
        restart_capture();
        checks++; if (oSize_Err !== 1'b0) begin errors++; $display("FAIL stats_clr: err got %b want 0", oSize_Err); end
        send_line(8, 8'h10, n, last);
        checks++; if (oSize_Err !== 1'b0 || oLine_Cnt !== 10'd1 || oPix_Cnt !== 10'd0) begin errors++; $display("FAIL stats_l1: err %b line %0d pix %0d want 0 1 0", oSize_Err, oLine_Cnt, oPix_Cnt); end
        send_line(6, 8'h20, n, last);
        checks++; if (oSize_Err !== 1'b1 || oLine_Cnt !== 10'd2) begin errors++; $display("FAIL stats_short: err %b line %0d want 1 2", oSize_Err, oLine_Cnt); end
        restart_capture();
        send_line(8, 8'h30, n, last);
        send_line(8, 8'h50, n, last);
        checks++; if (n !== 4 || oLine_Cnt !== 10'd2) begin errors++; $display("FAIL stats_good_lines: pix %0d line %0d want 4 2", n, oLine_Cnt); end
        vsync_pulse(saw);
        checks++; if (oSize_Err !== 1'b0 || oLine_Cnt !== 10'd0) begin errors++; $display("FAIL stats_good_frame: err %b line %0d want 0 0", oSize_Err, oLine_Cnt); end
`else
        send_line(6, 8'h60, n, last);
        vsync_pulse(saw);
        checks++; if (oLine_Cnt !== 10'd0 || oPix_Cnt !== 10'd0 || oSize_Err !== 1'b0) begin errors++; $display("FAIL stats_tied: line %0d pix %0d err %b want 0 0 0", oLine_Cnt, oPix_Cnt, oSize_Err); end
        checks++; if (n !== 3 || last !== 16'h6465) begin errors++; $display("FAIL stats_line: pix %0d data %h want 3 6465", n, last); end
`endif
    endtask

    initial begin
        iRST = 1'b1; iConfig_Done = 1'b0;
        iCMOS_VSYNC = 1'b0; iCMOS_HREF = 1'b0; iCMOS_DATA = 8'h00;
        test_reset();
        test_skip();
        test_pack();
        test_odd_line();
        test_reset_mid();
        test_cfg_drop();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
